// File: rtl/flag_event_source.sv
// ---------------------------------------------------------------------------
// flag_event_source
// Source side of the cross-domain sticky status flag. Accepts single-cycle
// event strobes with a data word, emits one set pulse per accepted event for
// the destination-side pulse synchronizer, and holds the event data until the
// reader acknowledges. Consecutive set pulses are spaced by at least GAP+1
// cycles. Events arriving while one is pending are dropped and counted.
//
// Ports
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_event       single-cycle event strobe
//   i_event_data  data captured with an accepted event
//   i_ack         single-cycle reader acknowledge (releases pending event)
//   i_clr_lost    single-cycle clear of o_lost_cnt / o_overflow
//   o_set_pulse   one-cycle pulse per accepted event
//   o_flag        event pending (accepted, not yet acknowledged)
//   o_data_out    data of the pending or last accepted event
//   o_lost_cnt    dropped-event count, saturating at all-ones
//   o_overflow    sticky, set on any dropped event
// ---------------------------------------------------------------------------
module flag_event_source #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int GAP    = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_event,
  input  logic [DATA_W-1:0] i_event_data,
  input  logic              i_ack,
  input  logic              i_clr_lost,
  output logic              o_set_pulse,
  output logic              o_flag,
  output logic [DATA_W-1:0] o_data_out,
  output logic [CNT_W-1:0]  o_lost_cnt,
  output logic              o_overflow
);

  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_ACK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  w_gap_cnt_nxt;
  logic        r_ack_seen;
  logic        w_ack_seen_nxt;
  logic        w_accept;
  logic        w_drop;
  logic        w_flag_nxt;

  logic              r_set_pulse;
  logic              r_flag;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_lost_cnt;
  logic              r_overflow;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_ack_seen_nxt = r_ack_seen;
    w_accept       = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_event;
      end
      S_HOLD: begin
        // Every event during HOLD is dropped: this enforces the pulse spacing.
        w_drop         = i_event;
        w_ack_seen_nxt = r_ack_seen | i_ack;
        if (r_gap_cnt == 8'd0) begin
          // An ack on the final HOLD cycle counts as well as an earlier one.
          w_state_nxt = (r_ack_seen || i_ack) ? S_IDLE : S_WAIT_ACK;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      S_WAIT_ACK: begin
        if (i_ack) begin
          // Same-cycle ack+event hands straight over to the new event.
          if (i_event) w_accept = 1'b1;
          else         w_state_nxt = S_IDLE;
        end else begin
          w_drop = i_event;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_nxt    = S_HOLD;
      w_gap_cnt_nxt  = GAP_M1;
      w_ack_seen_nxt = 1'b0;
    end
    w_flag_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= 8'd0;
      r_ack_seen  <= 1'b0;
      r_set_pulse <= 1'b0;
      r_flag      <= 1'b0;
      r_data      <= '0;
      r_lost_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_ack_seen  <= w_ack_seen_nxt;
      r_set_pulse <= w_accept;
      r_flag      <= w_flag_nxt;
      if (w_accept) r_data <= i_event_data;
      // A clear coinciding with a drop leaves exactly that one drop recorded.
      if (i_clr_lost) begin
        r_lost_cnt <= w_drop ? CNT_W'(1) : '0;
        r_overflow <= w_drop;
      end else if (w_drop) begin
        r_lost_cnt <= sat_inc(r_lost_cnt);
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_set_pulse = r_set_pulse;
  assign o_flag      = r_flag;
  assign o_data_out  = r_data;
  assign o_lost_cnt  = r_lost_cnt;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_flag_event_source.sv
module tb_flag_event_source;

  localparam int DATA_W = 32;
  localparam int GAP    = 4;

  logic              clk;
  logic              i_reset;
  logic              i_event;
  logic [DATA_W-1:0] i_event_data;
  logic              i_ack;
  logic              i_clr_lost;
  logic              o_set_pulse;
  logic              o_flag;
  logic [DATA_W-1:0] o_data_out;
  logic [7:0]        o_lost_cnt;
  logic              o_overflow;
  // Narrow-counter instance sharing the same stimulus.
  logic              b_set_pulse;
  logic              b_flag;
  logic [DATA_W-1:0] b_data_out;
  logic [1:0]        b_lost_cnt;
  logic              b_overflow;

  int checks = 0;
  int errors = 0;

  flag_event_source #(.DATA_W(DATA_W), .CNT_W(8), .GAP(GAP)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_event(i_event), .i_event_data(i_event_data),
    .i_ack(i_ack), .i_clr_lost(i_clr_lost), .o_set_pulse(o_set_pulse), .o_flag(o_flag),
    .o_data_out(o_data_out), .o_lost_cnt(o_lost_cnt), .o_overflow(o_overflow));

  flag_event_source #(.DATA_W(DATA_W), .CNT_W(2), .GAP(GAP)) u_dut_c2 (
    .i_clk(clk), .i_reset(i_reset), .i_event(i_event), .i_event_data(i_event_data),
    .i_ack(i_ack), .i_clr_lost(i_clr_lost), .o_set_pulse(b_set_pulse), .o_flag(b_flag),
    .o_data_out(b_data_out), .o_lost_cnt(b_lost_cnt), .o_overflow(b_overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time-stamped acceptance, outputs after each edge.
  int          cyc = 0;
  bit          m_flag, m_pulse, m_acked, m_ovf;
  int          m_acc, m_lost;
  logic [31:0] m_data;

  task automatic model_step(input bit ev, input logic [31:0] d, input bit ak,
                            input bit cl, input bit rs);
    bit accept, drop, release_ev;
    accept = 0; drop = 0; release_ev = 0;
    if (rs) begin
      m_flag = 0; m_pulse = 0; m_acked = 0; m_ovf = 0; m_lost = 0; m_data = '0; m_acc = 0;
    end else begin
      if (!m_flag) begin
        accept = ev;
      end else if (cyc <= m_acc + GAP) begin
        // Inside the spacing window that follows an acceptance.
        if (ak) m_acked = 1;
        if (cyc == m_acc + GAP && m_acked) release_ev = 1;
        drop = ev;
      end else begin
        if (ak && ev)  accept = 1;
        else if (ak)   release_ev = 1;
        else           drop = ev;
      end
      m_pulse = accept;
      if (accept) begin
        m_flag = 1; m_data = d; m_acc = cyc; m_acked = 0;
      end else if (release_ev) begin
        m_flag = 0;
      end
      if (cl) begin
        m_lost = drop ? 1 : 0;
        m_ovf  = drop;
      end else if (drop) begin
        m_lost++;
        m_ovf = 1;
      end
    end
    cyc++;
  endtask

  task automatic tick(input bit ev, input logic [31:0] d, input bit ak,
                      input bit cl, input bit rs);
    i_event = ev; i_event_data = d; i_ack = ak; i_clr_lost = cl; i_reset = rs;
    @(posedge clk);
    model_step(ev, d, ak, cl, rs);
    #1;
    i_event = 0; i_ack = 0; i_clr_lost = 0; i_reset = 0;
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 0, 1);
    checks++; if (o_flag !== 1'b0)      begin errors++; $display("FAIL reset_flag got %0b want 0", o_flag); end
    checks++; if (o_set_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", o_set_pulse); end
    checks++; if (o_data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_data_out); end
    checks++; if (o_lost_cnt !== 8'd0)  begin errors++; $display("FAIL reset_lost got %0d want 0", o_lost_cnt); end
    checks++; if (o_overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
  endtask

  task automatic test_basic;
    tick(0, 0, 0, 0, 1);
    tick(1, 32'hA5A5_0001, 0, 0, 0);   // edge n
    checks++; if (o_set_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse_n1 got %0b want 1", o_set_pulse); end
    checks++; if (o_flag !== 1'b1)      begin errors++; $display("FAIL basic_flag_n1 got %0b want 1", o_flag); end
    checks++; if (o_data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_data got %h want a5a50001", o_data_out); end
    for (int k = 2; k <= 8; k++) begin
      tick(0, 0, 0, 0, 0);
      checks++; if (o_set_pulse !== 1'b0 || o_flag !== 1'b1) begin
        errors++; $display("FAIL basic_hold_n%0d pulse %0b flag %0b want pulse 0 flag 1", k, o_set_pulse, o_flag);
      end
    end
    tick(0, 0, 1, 0, 0);               // ack at n+8
    checks++; if (o_flag !== 1'b0)     begin errors++; $display("FAIL basic_flag_n9 got %0b want 0", o_flag); end
    checks++; if (o_lost_cnt !== 8'd0) begin errors++; $display("FAIL basic_lost got %0d want 0", o_lost_cnt); end
  endtask

  task automatic test_drops;
    int pulses;
    tick(0, 0, 0, 0, 1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      tick(1, 32'h1111_0001, 0, 0, 0);
      else if (k == 2) tick(1, 32'h2222_0002, 0, 0, 0);
      else if (k == 6) tick(1, 32'h3333_0003, 0, 0, 0);
      else             tick(0, 0, 0, 0, 0);
      if (o_set_pulse) pulses++;
    end
    checks++; if (pulses != 1)          begin errors++; $display("FAIL drops_pulses got %0d want 1", pulses); end
    checks++; if (o_lost_cnt !== 8'd2)  begin errors++; $display("FAIL drops_lost got %0d want 2", o_lost_cnt); end
    checks++; if (o_overflow !== 1'b1)  begin errors++; $display("FAIL drops_ovf got %0b want 1", o_overflow); end
    checks++; if (o_data_out !== 32'h1111_0001) begin errors++; $display("FAIL drops_data got %h want 11110001", o_data_out); end
    checks++; if (o_flag !== 1'b1)      begin errors++; $display("FAIL drops_flag got %0b want 1", o_flag); end
  endtask

  task automatic test_ack_in_hold;
    tick(0, 0, 0, 0, 1);
    tick(1, 32'h0000_00AA, 0, 0, 0);   // n
    tick(0, 0, 0, 0, 0);               // n+1
    tick(0, 0, 1, 0, 0);               // n+2 ack
    checks++; if (o_flag !== 1'b1) begin errors++; $display("FAIL ackhold_flag_n3 got %0b want 1", o_flag); end
    tick(0, 0, 0, 0, 0);               // n+3
    checks++; if (o_flag !== 1'b1) begin errors++; $display("FAIL ackhold_flag_n4 got %0b want 1", o_flag); end
    tick(0, 0, 0, 0, 0);               // n+4
    checks++; if (o_flag !== 1'b0) begin errors++; $display("FAIL ackhold_flag_n5 got %0b want 0", o_flag); end
    tick(1, 32'h0000_00BB, 0, 0, 0);   // n+5 event
    checks++; if (o_set_pulse !== 1'b1) begin errors++; $display("FAIL ackhold_pulse_n6 got %0b want 1", o_set_pulse); end
    checks++; if (o_data_out !== 32'h0000_00BB) begin errors++; $display("FAIL ackhold_data got %h want 000000bb", o_data_out); end
  endtask

  task automatic test_back_to_back;
    tick(0, 0, 0, 0, 1);
    tick(1, 32'h0000_0055, 0, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0, 0);
    checks++; if (o_flag !== 1'b1) begin errors++; $display("FAIL b2b_flag_pre got %0b want 1", o_flag); end
    tick(1, 32'h0000_0077, 1, 0, 0);   // m: ack + event in WAIT_ACK
    checks++; if (o_flag !== 1'b1)      begin errors++; $display("FAIL b2b_flag got %0b want 1", o_flag); end
    checks++; if (o_set_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse got %0b want 1", o_set_pulse); end
    checks++; if (o_data_out !== 32'h0000_0077) begin errors++; $display("FAIL b2b_data got %h want 00000077", o_data_out); end
    checks++; if (o_lost_cnt !== 8'd0)  begin errors++; $display("FAIL b2b_lost got %0d want 0", o_lost_cnt); end
    tick(0, 0, 0, 0, 0);
    checks++; if (o_set_pulse !== 1'b0) begin errors++; $display("FAIL b2b_pulse_next got %0b want 0", o_set_pulse); end
  endtask

  task automatic test_saturation;
    tick(0, 0, 0, 0, 1);
    tick(1, 32'h0000_0001, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(1, 32'hDEAD_0000 + 32'(k), 0, 0, 0);
    checks++; if (o_lost_cnt !== 8'd5) begin errors++; $display("FAIL sat_lost8 got %0d want 5", o_lost_cnt); end
    checks++; if (b_lost_cnt !== 2'd3) begin errors++; $display("FAIL sat_lost2 got %0d want 3", b_lost_cnt); end
    checks++; if (b_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf2 got %0b want 1", b_overflow); end
    checks++; if (o_data_out !== 32'h0000_0001) begin errors++; $display("FAIL sat_data got %h want 00000001", o_data_out); end
    tick(1, 32'h0, 0, 1, 0);           // clear together with a drop
    checks++; if (b_lost_cnt !== 2'd1 || b_overflow !== 1'b1) begin
      errors++; $display("FAIL sat_clr_drop got lost %0d ovf %0b want lost 1 ovf 1", b_lost_cnt, b_overflow);
    end
    tick(0, 0, 0, 1, 0);               // clear alone
    checks++; if (b_lost_cnt !== 2'd0 || b_overflow !== 1'b0 || o_lost_cnt !== 8'd0) begin
      errors++; $display("FAIL sat_clr got lost %0d/%0d ovf %0b want 0/0 ovf 0", o_lost_cnt, b_lost_cnt, b_overflow);
    end
  endtask

  task automatic test_reset_in_hold;
    tick(0, 0, 0, 0, 1);
    tick(1, 32'h1234_5678, 0, 0, 0);
    checks++; if (o_set_pulse !== 1'b1) begin errors++; $display("FAIL rsthold_pulse got %0b want 1", o_set_pulse); end
    tick(0, 0, 0, 0, 1);               // reset in first HOLD cycle
    checks++; if (o_flag !== 1'b0 || o_set_pulse !== 1'b0 || o_data_out !== 32'h0) begin
      errors++; $display("FAIL rsthold_out got flag %0b pulse %0b data %h want 0 0 0", o_flag, o_set_pulse, o_data_out);
    end
    tick(0, 0, 1, 0, 0);               // ack while idle
    checks++; if (o_flag !== 1'b0 || o_set_pulse !== 1'b0 || o_data_out !== 32'h0) begin
      errors++; $display("FAIL idle_ack got flag %0b pulse %0b data %h want 0 0 0", o_flag, o_set_pulse, o_data_out);
    end
  endtask

  task automatic test_random;
    bit ev, ak, cl, rs, prev_pulse;
    logic [31:0] d;
    int exp8, exp2;
    tick(0, 0, 0, 0, 1);
    prev_pulse = 0;
    for (int k = 0; k < 4000; k++) begin
      ev = ($urandom % 3) == 0;
      ak = ($urandom % 7) == 0;
      cl = ($urandom % 50) == 0;
      rs = ($urandom % 400) == 0;
      d  = $urandom;
      tick(ev, d, ak, cl, rs);
      exp8 = (m_lost > 255) ? 255 : m_lost;
      exp2 = (m_lost > 3) ? 3 : m_lost;
      checks++; if (o_set_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d got %0b want %0b", cyc, o_set_pulse, m_pulse); end
      checks++; if (o_flag !== m_flag) begin errors++; $display("FAIL rnd_flag cyc %0d got %0b want %0b", cyc, o_flag, m_flag); end
      checks++; if (o_data_out !== m_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, o_data_out, m_data); end
      checks++; if (o_lost_cnt !== 8'(exp8)) begin errors++; $display("FAIL rnd_lost8 cyc %0d got %0d want %0d", cyc, o_lost_cnt, exp8); end
      checks++; if (b_lost_cnt !== 2'(exp2)) begin errors++; $display("FAIL rnd_lost2 cyc %0d got %0d want %0d", cyc, b_lost_cnt, exp2); end
      checks++; if (o_overflow !== m_ovf || b_overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cyc %0d got %0b/%0b want %0b", cyc, o_overflow, b_overflow, m_ovf);
      end
      checks++; if (prev_pulse && o_set_pulse) begin errors++; $display("FAIL rnd_pulse_adjacent cyc %0d got 1 want 0", cyc); end
      prev_pulse = o_set_pulse;
    end
  endtask

  initial begin
    i_reset = 1; i_event = 0; i_event_data = '0; i_ack = 0; i_clr_lost = 0;
    m_flag = 0; m_pulse = 0; m_acked = 0; m_ovf = 0; m_acc = 0; m_lost = 0; m_data = '0;
    test_reset;
    test_basic;
    test_drops;
    test_ack_in_hold;
    test_back_to_back;
    test_saturation;
    test_reset_in_hold;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
